// File: rtl/cpu_machine_ctrl_if.sv
// Control bus between the instruction-cycle controller and the CPU datapath.
// The datapath side (master) supplies the clk_gen fetch phase, the IR opcode
// field and the accumulator zero flag. The controller side (slave) returns
// the datapath strobes, the halt flag and the current state code.
interface cpu_machine_ctrl_if;
  logic       fetch;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc;
  logic       load_pc;
  logic       load_acc;
  logic       load_ir;
  logic       rd;
  logic       wr;
  logic       datactl_ena;
  logic       halt;
  logic [3:0] state;

  modport master (
    output fetch, opcode, zero,
    input  inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, state
  );

  modport slave (
    input  fetch, opcode, zero,
    output inc_pc, load_pc, load_acc, load_ir, rd, wr, datactl_ena, halt, state
  );
endinterface

// File: rtl/cpu_machine_ctrl.sv
// Instruction-cycle controller for the simple RISC CPU.
// After reset it idles until the first clk_gen fetch, then free-runs an
// 8-slot instruction cycle (S0..S7). Each slot decodes opcode and zero into
// datapath strobes. HLT parks the machine in HALTED.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - slave side of cpu_machine_ctrl_if (fetch/opcode/zero in,
//           inc_pc/load_pc/load_acc/load_ir/rd/wr/datactl_ena/halt/state out)
// HALT_RESUME: 0 = only reset leaves HALTED, 1 = fetch also resumes at S0.
module cpu_machine_ctrl #(
  parameter bit HALT_RESUME = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  cpu_machine_ctrl_if.slave   bus
);

  localparam logic [2:0] OP_HLT  = 3'b000;
  localparam logic [2:0] OP_SKZ  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_ANDD = 3'b011;
  localparam logic [2:0] OP_XORR = 3'b100;
  localparam logic [2:0] OP_LDA  = 3'b101;
  localparam logic [2:0] OP_STO  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [3:0] {
    S0     = 4'h0,
    S1     = 4'h1,
    S2     = 4'h2,
    S3     = 4'h3,
    S4     = 4'h4,
    S5     = 4'h5,
    S6     = 4'h6,
    S7     = 4'h7,
    IDLE   = 4'h8,
    HALTED = 4'h9
  } state_t;

  state_t cur, nxt;

  logic alu_op, jmp_op, sto_op, skz_taken, hlt_op;

  // ALU group reads its operand from memory in S4/S5 and loads acc in S5.
  assign alu_op    = (bus.opcode == OP_ADD)  || (bus.opcode == OP_ANDD) ||
                     (bus.opcode == OP_XORR) || (bus.opcode == OP_LDA);
  assign jmp_op    = (bus.opcode == OP_JMP);
  assign sto_op    = (bus.opcode == OP_STO);
  assign hlt_op    = (bus.opcode == OP_HLT);
  // zero is looked at live, so a change between S5 and S7 only moves S7.
  assign skz_taken = (bus.opcode == OP_SKZ) && bus.zero;

  always_ff @(posedge clk) begin
    if (reset) cur <= IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt             = IDLE;
    bus.inc_pc      = 1'b0;
    bus.load_pc     = 1'b0;
    bus.load_acc    = 1'b0;
    bus.load_ir     = 1'b0;
    bus.rd          = 1'b0;
    bus.wr          = 1'b0;
    bus.datactl_ena = 1'b0;
    bus.halt        = 1'b0;
    unique case (cur)
      IDLE: nxt = bus.fetch ? S0 : IDLE;
      S0: begin
        nxt         = S1;
        bus.rd      = 1'b1;
        bus.load_ir = 1'b1;
      end
      S1: begin
        nxt         = S2;
        bus.rd      = 1'b1;
        bus.load_ir = 1'b1;
        bus.inc_pc  = 1'b1;
      end
      S2: nxt = S3;
      S3: begin
        nxt        = hlt_op ? HALTED : S4;
        bus.inc_pc = 1'b1;
        bus.halt   = hlt_op;
      end
      S4: begin
        nxt             = S5;
        bus.rd          = alu_op;
        bus.load_pc     = jmp_op;
        bus.datactl_ena = sto_op;
      end
      S5: begin
        nxt             = S6;
        bus.rd          = alu_op;
        bus.load_acc    = alu_op;
        bus.load_pc     = jmp_op;
        bus.inc_pc      = jmp_op || skz_taken;
        bus.datactl_ena = sto_op;
        bus.wr          = sto_op;
      end
      S6: begin
        nxt             = S7;
        bus.datactl_ena = sto_op;
      end
      S7: begin
        nxt        = S0;
        bus.inc_pc = skz_taken;
      end
      HALTED: begin
        nxt      = (HALT_RESUME && bus.fetch) ? S0 : HALTED;
        bus.halt = 1'b1;
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.state = cur;

endmodule

// File: doc/cpu_machine_ctrl.md
# cpu_machine_ctrl

Instruction-cycle controller for the simple RISC CPU, directly downstream of `clk_gen`. It waits for the first `fetch` from `clk_gen` after reset, then free-runs an 8-state instruction cycle. In each state it decodes the 3-bit opcode and the accumulator zero flag into the datapath strobes that drive the PC, IR, accumulator and memory bus.

## Interface
- `HALT_RESUME`, default 0: 0 = only reset leaves HALTED; 1 = `fetch`=1 sampled in HALTED moves to S0.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `fetch`  in  1  `clk_gen` fetch phase; sampled only in IDLE (and HALTED when `HALT_RESUME`=1).
- `opcode`  in  3  IR[15:13]; stable from S2 onward.
- `zero`  in  1  accumulator == 0 flag.
- `inc_pc`  out  1  PC increment strobe.
- `load_pc`  out  1  PC load from IR address.
- `load_acc`  out  1  accumulator load from ALU.
- `load_ir`  out  1  IR byte load.
- `rd`  out  1  memory read.
- `wr`  out  1  memory write.
- `datactl_ena`  out  1  drive ALU result onto data bus.
- `halt`  out  1  CPU halted.
- `state`  out  4  current state code (debug/verification).

## Operation
- Opcodes: HLT 000, SKZ 001, ADD 010, ANDD 011, XORR 100, LDA 101, STO 110, JMP 111. ALU group = ADD, ANDD, XORR, LDA.
- States and codes: IDLE 4'h8, S0..S7 4'h0..4'h7, HALTED 4'h9. Unused codes go to IDLE on the next clock.
- Outputs are a combinational decode of the registered state, `opcode` and `zero`. Any strobe not listed for a state is 0.
- IDLE: all strobes 0. Moves to S0 on the clock where `fetch`=1; otherwise stays.
- S0: `rd`, `load_ir` (high byte).
- S1: `rd`, `load_ir`, `inc_pc` (low byte).
- S2: all strobes 0 (decode slot).
- S3: `inc_pc`. If HLT, also `halt`, and the next state is HALTED instead of S4.
- S4:
  - ALU group: `rd`.
  - JMP: `load_pc`.
  - STO: `datactl_ena`.
- S5:
  - ALU group: `rd`, `load_acc`.
  - JMP: `load_pc`, `inc_pc`.
  - STO: `datactl_ena`, `wr`.
  - SKZ with `zero`=1: `inc_pc`.
- S6: STO: `datactl_ena`.
- S7: SKZ with `zero`=1: `inc_pc`. A taken SKZ therefore gives two extra increments, skipping one 2-byte instruction.
- S7 → S0 unconditionally. `fetch` is ignored outside IDLE and HALTED.
- HALTED: `halt`=1, all other strobes 0. Exit rules:
  - `HALT_RESUME`=0: only reset exits.
  - `HALT_RESUME`=1: `fetch`=1 moves to S0.
- `wr` and `rd` are never 1 in the same cycle. `load_pc` is only ever 1 for JMP.

## Timing
- Reset: on the reset clock edge, state=IDLE (4'h8). While in IDLE, all strobes and `halt` are 0.
- Reset overrides everything, including mid-cycle and HALTED. The cycle after reset is deasserted is IDLE, whatever `fetch` was.
- Start latency: `fetch` sampled 1 at edge N means state=S0 after edge N.
- After start, one instruction takes exactly 8 clocks, back-to-back with no gaps.
- `zero` is evaluated in the same cycle it is used (S5, S7). A `zero` change between S5 and S7 affects only the S7 strobe.
- HLT: `halt` rises in S3 and stays 1 from HALTED onward.

## Test plan
- Reset held 3 clocks, `fetch`=0 for 5 more clocks → `state`=4'h8, all outputs 0. Then `fetch`=1 → S0 next clock, with `rd`=`load_ir`=1.
- Opcode LDA (101), `zero`=0, one full cycle → `inc_pc` high in S1 and S3 only; `rd` high in S0, S1, S4, S5; `load_acc` high in S5 only; `wr`=0 throughout.
- Opcode SKZ (001): with `zero`=1 → `inc_pc` high in S1, S3, S5, S7 (4 pulses); with `zero`=0 → S1, S3 only (2 pulses).
- Opcode STO (110) → `datactl_ena` high in S4–S6; `wr` high only in S5; `rd` low in S4–S7.
- Opcode HLT (000) → `halt` in S3, `state`=4'h9 from the next clock. Then `fetch` pulses:
  - `HALT_RESUME`=0: no exit.
  - `HALT_RESUME`=1: S0 follows.
- JMP (111), reset asserted in S5 → IDLE next clock, all strobes 0. Then wait for `fetch` and check that the cycle restarts at S0.
